// File: rtl/vpg_pkg.sv
// Shared definitions for the AXI4-Stream video pattern generator:
// pattern codes, colour-bar table and FSM state encoding.
package vpg_pkg;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_CHECK = 2'd1;
  localparam logic [1:0] PAT_GRAD  = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  // Index 0 is the rightmost entry: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

endpackage

// File: rtl/vpg_pixel_calc.sv
// Combinational pixel function: maps pattern, coordinates, bar index and
// solid colour to a 24-bit RGB pixel.
module vpg_pixel_calc
  import vpg_pkg::*;
#(
  parameter int unsigned XW          = 10,
  parameter int unsigned YW          = 9,
  parameter int unsigned CHECK_SHIFT = 5
) (
  input  logic [1:0]    pattern_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  logic [2:0]    bar_i,
  input  logic [23:0]   solid_i,
  output logic [23:0]   pixel_o
);

  logic       chk_bit;
  logic [7:0] x8;
  logic [7:0] y8;

  always_comb begin
    chk_bit = (|((x_i >> CHECK_SHIFT) & XW'(1))) ^ (|((y_i >> CHECK_SHIFT) & YW'(1)));
    x8      = 8'(x_i);
    y8      = 8'(y_i);
    pixel_o = '0;
    case (pattern_i)
      PAT_BARS:  pixel_o = BAR_RGB[bar_i];
      PAT_CHECK: pixel_o = chk_bit ? '1 : '0;
      PAT_GRAD:  pixel_o = {x8, y8, 8'(x8 + y8)};
      default:   pixel_o = solid_i;
    endcase
  end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream test-frame source: colour bars, checkerboard, gradient or solid,
// with TREADY backpressure, TUSER start-of-frame and an idle gap between frames.
module axis_video_pattern_gen
  import vpg_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned FRAME_GAP   = 16,
  parameter int unsigned CHECK_SHIFT = 5
) (
  input  logic        axi_clk,
  input  logic        axi_resetn,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int unsigned XW  = $clog2(H_ACTIVE);
  localparam int unsigned YW  = (V_ACTIVE > 2) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned BW  = $clog2(H_ACTIVE / 8);
  localparam int unsigned GW  = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(H_ACTIVE / 8 - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(FRAME_GAP - 1);

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d, x_n;
  logic [YW-1:0] y_q, y_d, y_n;
  logic [2:0]    bar_q, bar_d, bar_n;
  logic [BW-1:0] bcnt_q, bcnt_d, bcnt_n;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    pat_q, pat_d;
  logic [23:0]   solid_q, solid_d;
  logic [23:0]   tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic [15:0]   fcnt_q, fcnt_d;

  logic          start, xfer;
  logic [1:0]    calc_pat;
  logic [XW-1:0] calc_x;
  logic [YW-1:0] calc_y;
  logic [2:0]    calc_bar;
  logic [23:0]   calc_solid, pixel;

  // Post-transfer counters; the pixel for them is precomputed so tdata is ready
  // on the cycle after each transfer without a bubble.
  always_comb begin
    x_n    = x_q + 1'b1;
    y_n    = y_q;
    bar_n  = bar_q;
    bcnt_n = bcnt_q + 1'b1;
    if (bcnt_q == BCNT_LAST) begin
      bcnt_n = '0;
      bar_n  = bar_q + 1'b1;
    end
    if (x_q == X_LAST) begin
      x_n    = '0;
      bar_n  = '0;
      bcnt_n = '0;
      y_n    = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
    end
    xfer  = tvalid_q & m_axis_tready;
    start = enable & ((state_q == ST_IDLE) | ((state_q == ST_GAP) & (gap_q == GAP_LAST)));
    calc_pat   = start ? pattern_sel : pat_q;
    calc_solid = start ? solid_rgb : solid_q;
    calc_x     = start ? '0 : x_n;
    calc_y     = start ? '0 : y_n;
    calc_bar   = start ? '0 : bar_n;
  end

  vpg_pixel_calc #(
    .XW         (XW),
    .YW         (YW),
    .CHECK_SHIFT(CHECK_SHIFT)
  ) u_pixel_calc (
    .pattern_i(calc_pat),
    .x_i      (calc_x),
    .y_i      (calc_y),
    .bar_i    (calc_bar),
    .solid_i  (calc_solid),
    .pixel_o  (pixel)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    bar_d    = bar_q;
    bcnt_d   = bcnt_q;
    gap_d    = gap_q;
    pat_d    = pat_q;
    solid_d  = solid_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    fcnt_d   = fcnt_q;
    case (state_q)
      ST_IDLE: ;
      ST_ACTIVE: begin
        if (xfer) begin
          if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
            fcnt_d   = fcnt_q + 16'd1;
            x_d      = '0;
            y_d      = '0;
            bar_d    = '0;
            bcnt_d   = '0;
            gap_d    = '0;
            tdata_d  = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
            state_d  = ST_GAP;
          end else begin
            x_d     = x_n;
            y_d     = y_n;
            bar_d   = bar_n;
            bcnt_d  = bcnt_n;
            tdata_d = pixel;
            tlast_d = (x_n == X_LAST);
            tuser_d = (x_n == '0) && (y_n == '0);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Frame start from IDLE or end of GAP overrides the per-state updates above.
    if (start) begin
      state_d  = ST_ACTIVE;
      pat_d    = pattern_sel;
      solid_d  = solid_rgb;
      x_d      = '0;
      y_d      = '0;
      bar_d    = '0;
      bcnt_d   = '0;
      tdata_d  = pixel;
      tvalid_d = 1'b1;
      tlast_d  = 1'b0;
      tuser_d  = 1'b1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      bar_q    <= '0;
      bcnt_q   <= '0;
      gap_q    <= '0;
      pat_q    <= '0;
      solid_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      bar_q    <= bar_d;
      bcnt_q   <= bcnt_d;
      gap_q    <= gap_d;
      pat_q    <= pat_d;
      solid_q  <= solid_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_count   = fcnt_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
